snax_exercise_acc: RTL and testbench
====================================

# snax_exercise_acc

Output-stationary accumulator directly downstream of the exercise dot-product PE. It consumes the PE's 2*DataWidth result stream and sums a programmed number of partial results into one accumulator. It then presents the final sum on a valid/ready output port toward the writer streamer. It drives the PE's `out_ready_i` and `acc_ready_i`, so the PE only fires while an accumulation is in progress.

## Interface
- `DataWidth`, 64: PE operand width; the input and result width is 2*DataWidth.
- `RegDataWidth`, 32: CSR width of the length register.
- `clk_i` in 1: clock. One clock; reset is synchronous and active-high.
- `rst_i` in 1: synchronous active-high reset.
- `in_i` in 2*DataWidth: partial result from the PE `out_o`.
- `in_valid_i` in 1: from the PE `out_valid_o`.
- `in_ready_o` out 1: to the PE `out_ready_i`.
- `acc_ready_o` out 1: to the PE `acc_ready_i`.
- `start_i` in 1: one-cycle start pulse from the CSR manager.
- `acc_len_i` in RegDataWidth: number of partial results to sum. Sampled at start.
- `res_o` out 2*DataWidth: final accumulated sum.
- `res_valid_o` out 1: result valid.
- `res_ready_i` in 1: result ready.
- `busy_o` out 1: high whenever the state is not IDLE.
- `done_o` out 1: one-cycle pulse when a job completes.

## Operation
- FSM states: IDLE, ACC, OUT.
- **IDLE**
  - `in_ready_o`, `acc_ready_o` and `res_valid_o` are all 0.
  - On `start_i` with `acc_len_i` != 0: latch `len` = `acc_len_i`, clear `acc` and `cnt`, and go to ACC.
  - On `start_i` with `acc_len_i` == 0: stay in IDLE and pulse `done_o` the next cycle. No result is produced.
- **ACC**
  - `in_ready_o` = `acc_ready_o` = 1.
  - On an input handshake (`in_valid_i` && `in_ready_o`): `acc` <= `acc` + `in_i` and `cnt` <= `cnt` + 1.
  - If the handshake happens when `cnt` == `len`-1, also go to OUT.
- **OUT**
  - `res_valid_o` = 1; input readies are 0.
  - `res_o` = `acc`, held stable until the handshake.
  - On `res_valid_o` && `res_ready_i`: go to IDLE and pulse `done_o` on the next cycle.
- Arithmetic:
  - Unsigned sum modulo 2^(2*DataWidth); overflow wraps silently.
  - `cnt` is RegDataWidth bits wide; `len` = 2^RegDataWidth-1 is legal.
- `start_i` outside IDLE is ignored, and `len` is not re-sampled.
- `res_o` is not cleared by the output handshake. It keeps the last sum until the next start clears `acc`.

## Timing
- Reset: state IDLE; `acc`, `cnt`, `len` = 0; `res_o` = 0; `busy_o`, `done_o`, `res_valid_o`, `in_ready_o`, `acc_ready_o` = 0.
- `start_i` in cycle t: `busy_o` and `in_ready_o` go high in cycle t+1.
- Input handshakes are accepted back-to-back, one per cycle, with no bubbles.
- Last input handshake in cycle t: `res_valid_o` = 1 in cycle t+1, carrying the full sum including that input.
- Output handshake in cycle t: `done_o` = 1 and `busy_o` = 0 in cycle t+1. A new `start_i` is accepted in that same cycle t+1.
- Ready outputs are registered state decodes, with no combinational path from `in_valid_i`. This is required because PE valid depends combinationally on these readies.
- Reset asserted mid-job: return to IDLE next cycle with all state cleared. No `done_o` pulse.
- `res_ready_i` held low: remain in OUT indefinitely with `res_o` stable.

## Structure
- Shared package `snax_exercise_pkg` holds:
  - The state enum `acc_state_e` (IDLE, ACC, OUT).
  - The result width constant.
- No sub-module is natural: one FSM, one counter and one adder in a single module.

## Test plan
- **Basic:** `start_i` with `acc_len_i`=4; inputs 1, 2, 3, 4 back-to-back; `res_ready_i`=1. Expect `res_valid_o` one cycle after the 4th input with `res_o`=10, then `done_o` the following cycle.
- **Input bubbles:** `acc_len_i`=3; `in_valid_i` toggled 1,0,0,1,0,1 with values 5, 7, 9. Expect exactly 3 handshakes and `res_o`=21.
- **Output backpressure:** `acc_len_i`=2; inputs 0x10, 0x20; `res_ready_i` held low for 5 cycles.
  - `res_valid_o` and `res_o`=0x30 stay stable and `in_ready_o`=0 throughout.
  - `done_o` pulses one cycle after `res_ready_i` rises.
- **Wrap and zero length:**
  - `acc_len_i`=2; inputs 2^128-1 and 3. Expect `res_o`=2.
  - `start_i` with `acc_len_i`=0. Expect only a `done_o` pulse and `busy_o` staying 0.
- **Ignored start and back-to-back jobs:** `start_i` pulsed during ACC with `acc_len_i`=9 leaves `len` unchanged. A new `start_i` in the `done_o` cycle begins the next job with `acc` cleared.
- **Reset mid-job:** `rst_i` asserted after 2 of 4 inputs. Expect all outputs 0 next cycle and no `done_o`. A fresh job with `acc_len_i`=1 and input 7 then gives `res_o`=7.

Source files
------------

// File: rtl/snax_exercise_pkg.sv
// rtl/snax_exercise_pkg.sv - shared types and constants for the exercise accumulator
package snax_exercise_pkg;

  // Width of the PE result stream and of the accumulated sum.
  localparam int unsigned ExerciseResWidth = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } acc_state_e;

endpackage

// File: rtl/snax_exercise_acc.sv
// rtl/snax_exercise_acc.sv - output-stationary accumulator behind the exercise dot-product PE
module snax_exercise_acc
  import snax_exercise_pkg::*;
#(
  parameter int unsigned DataWidth    = 64,
  parameter int unsigned RegDataWidth = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [2*DataWidth-1:0]    in_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  output logic                      acc_ready_o,
  input  logic                      start_i,
  input  logic [RegDataWidth-1:0]   acc_len_i,
  output logic [2*DataWidth-1:0]    res_o,
  output logic                      res_valid_o,
  input  logic                      res_ready_i,
  output logic                      busy_o,
  output logic                      done_o
);

  acc_state_e              state_q, state_d;
  logic [2*DataWidth-1:0]  acc_q, acc_d;
  logic [RegDataWidth-1:0] cnt_q, cnt_d;
  logic [RegDataWidth-1:0] len_q, len_d;
  logic                    done_q, done_d;

  // Next-state logic: job sequencing, accumulation and the completion pulse.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (acc_len_i != '0) begin
            len_d   = acc_len_i;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = ACC;
          end else begin
            // Empty job: report completion without producing a result.
            done_d = 1'b1;
          end
        end
      end
      ACC: begin
        // in_ready_o is 1 in this state, so in_valid_i alone marks a handshake.
        if (in_valid_i) begin
          acc_d = acc_q + in_i;
          cnt_d = cnt_q + RegDataWidth'(1);
          if (cnt_q == len_q - RegDataWidth'(1)) begin
            state_d = OUT;
          end
        end
      end
      OUT: begin
        if (res_ready_i) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      done_q  <= done_d;
    end
  end

  // Readies are pure state decodes: the PE's valid depends on them combinationally.
  assign in_ready_o  = (state_q == ACC);
  assign acc_ready_o = (state_q == ACC);
  assign res_valid_o = (state_q == OUT);
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign res_o       = acc_q;

endmodule

// File: tb/tb_snax_exercise_acc.sv
// tb/tb_snax_exercise_acc.sv - self-checking bench for snax_exercise_acc
module tb_snax_exercise_acc;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [127:0] in_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic         acc_ready_o;
  logic         start_i;
  logic [31:0]  acc_len_i;
  logic [127:0] res_o;
  logic         res_valid_o;
  logic         res_ready_i;
  logic         busy_o;
  logic         done_o;

  int total  = 0;
  int passed = 0;

  // Stimulus for the next job: partial results and idle cycles before each one.
  logic [127:0] vals_q[$];
  int           gaps_q[$];

  snax_exercise_acc #(.DataWidth(64), .RegDataWidth(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_i(in_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .acc_ready_o(acc_ready_o),
    .start_i(start_i), .acc_len_i(acc_len_i),
    .res_o(res_o), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Model: the result is the wrapped sum of every accepted partial result.
  function automatic logic [127:0] model_sum();
    logic [127:0] s = '0;
    foreach (vals_q[i]) s = s + vals_q[i];
    return s;
  endfunction

  // Runs one job from vals_q/gaps_q; ends in the cycle where done_o should be high.
  task automatic run_job(input int hold, input bit ign_start);
    logic [127:0] exp = model_sum();
    int n = vals_q.size();
    start_i = 1'b1; acc_len_i = n;
    step();
    start_i = 1'b0; acc_len_i = 32'd0;
    chk("busy_after_start", busy_o, 1);
    chk("in_ready_after_start", in_ready_o, 1);
    chk("acc_ready_after_start", acc_ready_o, 1);
    chk("done_low_in_job", done_o, 0);
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gaps_q[i]; g++) begin
        in_valid_i = 1'b0; in_i = rand128();
        step();
        chk("ready_held_in_bubble", in_ready_o, 1);
      end
      chk("no_result_early", res_valid_o, 0);
      in_valid_i = 1'b1; in_i = vals_q[i];
      if (ign_start && i == 1) begin
        start_i = 1'b1; acc_len_i = 32'd9;
      end
      step();
      start_i = 1'b0; acc_len_i = 32'd0;
    end
    in_valid_i = 1'b0; in_i = rand128();
    chk("res_valid_after_last", res_valid_o, 1);
    chk("res_sum", res_o, exp);
    chk("in_ready_low_in_out", in_ready_o, 0);
    chk("acc_ready_low_in_out", acc_ready_o, 0);
    for (int h = 0; h < hold; h++) begin
      res_ready_i = 1'b0;
      step();
      chk("bp_valid_held", res_valid_o, 1);
      chk("bp_res_stable", res_o, exp);
      chk("bp_in_ready_low", in_ready_o, 0);
      chk("bp_no_done", done_o, 0);
    end
    res_ready_i = 1'b1;
    step();
    res_ready_i = 1'b0;
    chk("done_pulse", done_o, 1);
    chk("busy_low_at_done", busy_o, 0);
    chk("res_valid_low_at_done", res_valid_o, 0);
    chk("res_kept_after_hs", res_o, exp);
  endtask

  task automatic set_job(input int n, input bit rand_gaps);
    vals_q.delete(); gaps_q.delete();
    for (int i = 0; i < n; i++) begin
      vals_q.push_back(rand128());
      gaps_q.push_back(rand_gaps ? int'($urandom_range(0, 2)) : 0);
    end
  endtask

  initial begin
    rst_i = 1'b1; in_i = '0; in_valid_i = 1'b0; start_i = 1'b0;
    acc_len_i = '0; res_ready_i = 1'b0;
    step(); step();
    rst_i = 1'b0;
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_res_valid", res_valid_o, 0);
    chk("rst_in_ready", in_ready_o, 0);
    chk("rst_acc_ready", acc_ready_o, 0);
    chk("rst_res", res_o, 0);

    // Basic: 1+2+3+4.
    vals_q = '{128'd1, 128'd2, 128'd3, 128'd4}; gaps_q = '{0, 0, 0, 0};
    run_job(0, 0);
    chk("basic_const", res_o, 128'd10);
    step();
    chk("done_one_cycle", done_o, 0);

    // Input bubbles: valid pattern 1,0,0,1,0,1.
    vals_q = '{128'd5, 128'd7, 128'd9}; gaps_q = '{0, 2, 1};
    run_job(0, 0);
    chk("bubble_const", res_o, 128'd21);
    step();

    // Output backpressure for 5 cycles.
    vals_q = '{128'h10, 128'h20}; gaps_q = '{0, 0};
    run_job(5, 0);
    chk("bp_const", res_o, 128'h30);
    step();

    // Wraparound.
    vals_q = '{{128{1'b1}}, 128'd3}; gaps_q = '{0, 0};
    run_job(0, 0);
    chk("wrap_const", res_o, 128'd2);
    step();

    // Zero length: only a done pulse.
    start_i = 1'b1; acc_len_i = 32'd0;
    step();
    start_i = 1'b0;
    chk("zero_done", done_o, 1);
    chk("zero_busy", busy_o, 0);
    chk("zero_no_valid", res_valid_o, 0);
    step();
    chk("zero_done_drop", done_o, 0);
    chk("zero_busy_stay", busy_o, 0);

    // Ignored start during ACC, then a new job started in the done cycle.
    vals_q = '{128'd100, 128'd200, 128'd300}; gaps_q = '{0, 0, 0};
    run_job(1, 1);
    set_job(3, 1);
    run_job(2, 0);
    step();

    // Reset mid-job after 2 of 4 inputs.
    start_i = 1'b1; acc_len_i = 32'd4;
    step();
    start_i = 1'b0;
    in_valid_i = 1'b1; in_i = 128'd11; step();
    in_i = 128'd22; step();
    rst_i = 1'b1; in_i = 128'd33; step();
    rst_i = 1'b0; in_valid_i = 1'b0;
    chk("mrst_busy", busy_o, 0);
    chk("mrst_in_ready", in_ready_o, 0);
    chk("mrst_res_valid", res_valid_o, 0);
    chk("mrst_res", res_o, 0);
    chk("mrst_done", done_o, 0);
    step();
    chk("mrst_no_done_later", done_o, 0);
    vals_q = '{128'd7}; gaps_q = '{0};
    run_job(0, 0);
    chk("after_rst_const", res_o, 128'd7);
    step();

    // Randomized jobs.
    for (int j = 0; j < 6; j++) begin
      set_job(int'($urandom_range(1, 6)), 1);
      run_job(int'($urandom_range(0, 3)), 0);
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Watchdog against a wedged simulation.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
